pwm_demodulador: RTL and testbench

//  Receive-side counterpart of the 8-bit PWM generator (period 2^N clk_in cycles,

---
 rtl/pwm_pkg.sv | 22 ++
 rtl/pwm_demodulador_sincronizador.sv | 37 +++
 rtl/pwm_demodulador.sv | 130 +++++++++++++
 tb/tb_pwm_demodulador.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
//==============================================================================
// Module  : pwm_pkg
// Brief   : Shared PWM definitions: default period width, duty word, FSM states.
// Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package pwm_pkg;

  localparam int c_periodo_bits = 8;

  typedef logic [c_periodo_bits-1:0] dato_t;

  typedef enum logic [0:0] {
    BUSCAR = 1'b0,
    MEDIR  = 1'b1
  } estado_t;

endpackage

`default_nettype wire

// File: rtl/pwm_demodulador_sincronizador.sv
//==============================================================================
// Module  : sincronizador
// Brief   : SYNC_STAGES-deep metastability chain for PWM_in plus rising-edge detect.
// Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module sincronizador #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic pwm_in,
  output logic sincronizada,
  output logic flanco
);

  logic [SYNC_STAGES-1:0] r_cadena;
  logic                   r_previa;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_cadena <= '0;
      r_previa <= 1'b0;
    end else begin
      r_cadena <= {r_cadena[SYNC_STAGES-2:0], pwm_in};
      r_previa <= r_cadena[SYNC_STAGES-1];
    end
  end

  assign sincronizada = r_cadena[SYNC_STAGES-1];
  assign flanco       = sincronizada & ~r_previa;

endmodule

`default_nettype wire

// File: rtl/pwm_demodulador.sv
//==============================================================================
// Module  : pwm_demodulador
// Brief   : Aligns to the PWM period boundary, counts high samples per period and
//           strobes the recovered duty word; flags misaligned edges / stuck-high.
// Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module pwm_demodulador
  import pwm_pkg::*;
#(
  parameter int PERIODO_BITS = c_periodo_bits,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic                    PWM_in,
  output logic [PERIODO_BITS-1:0] Dato_out,
  output logic                    dato_valido,
  output logic                    bloqueado,
  output logic                    error_sinc
);

  localparam logic [PERIODO_BITS-1:0] c_max = '1;

  logic [1:0]              r_rst_sync;
  logic                    w_rst_n;
  logic                    w_s;
  logic                    w_flanco;

  estado_t                 r_estado, w_estado_sig;
  logic [PERIODO_BITS-1:0] r_cnt, w_cnt_sig;
  logic [PERIODO_BITS:0]   r_acum, w_acum_sig, w_suma;
  logic [PERIODO_BITS-1:0] r_dato, w_dato_sig;
  logic                    r_valido, w_valido_sig;
  logic                    r_bloq, w_bloq_sig;
  logic                    r_error, w_error_sig;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  sincronizador #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sincronizador (
    .clk_in       (clk_in),
    .rst_n        (w_rst_n),
    .pwm_in       (PWM_in),
    .sincronizada (w_s),
    .flanco       (w_flanco)
  );

  assign w_suma = r_acum + (PERIODO_BITS+1)'(w_s);

  always_comb begin
    w_estado_sig = r_estado;
    w_cnt_sig    = r_cnt + 1'b1;
    w_acum_sig   = r_acum;
    w_dato_sig   = r_dato;
    w_valido_sig = 1'b0;
    w_error_sig  = 1'b0;
    w_bloq_sig   = r_bloq;
    case (r_estado)
      BUSCAR: begin
        if (w_flanco) begin
          w_cnt_sig    = PERIODO_BITS'(1);
          w_acum_sig   = (PERIODO_BITS+1)'(1);
          w_bloq_sig   = 1'b1;
          w_estado_sig = MEDIR;
        end else if (r_cnt == c_max) begin
          // Unlocked: a flat line is either Dato=0 or stuck high.
          w_dato_sig   = w_s ? c_max : '0;
          w_valido_sig = 1'b1;
          w_error_sig  = w_s;
        end
      end
      MEDIR: begin
        if (w_flanco && (r_cnt != '0)) begin
          w_cnt_sig   = PERIODO_BITS'(1);
          w_acum_sig  = (PERIODO_BITS+1)'(1);
          w_error_sig = 1'b1;
        end else if (r_cnt == c_max) begin
          w_valido_sig = 1'b1;
          w_acum_sig   = '0;
          if (w_suma[PERIODO_BITS]) begin
            w_dato_sig  = c_max;
            w_error_sig = 1'b1;
          end else begin
            w_dato_sig = w_suma[PERIODO_BITS-1:0];
          end
        end else begin
          w_acum_sig = w_suma;
        end
      end
      default: w_estado_sig = BUSCAR;
    endcase
  end

  always_ff @(posedge clk_in or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_estado <= BUSCAR;
      r_cnt    <= '0;
      r_acum   <= '0;
      r_dato   <= '0;
      r_valido <= 1'b0;
      r_bloq   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_estado <= w_estado_sig;
      r_cnt    <= w_cnt_sig;
      r_acum   <= w_acum_sig;
      r_dato   <= w_dato_sig;
      r_valido <= w_valido_sig;
      r_bloq   <= w_bloq_sig;
      r_error  <= w_error_sig;
    end
  end

  assign Dato_out    = r_dato;
  assign dato_valido = r_valido;
  assign bloqueado   = r_bloq;
  assign error_sinc  = r_error;

endmodule

`default_nettype wire

// File: tb/tb_pwm_demodulador.sv
//==============================================================================
// Module  : tb_pwm_demodulador
// Brief   : Scoreboard bench: behavioural PWM source, expected strobes queued per
//           generated period, monitor pops on every DUT output event.
// Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pwm_demodulador;

  localparam int N   = 8;
  localparam int PER = 1 << N;

  logic         clk_in = 1'b0;
  logic         rst_n  = 1'b0;
  logic         PWM_in = 1'b0;
  logic [N-1:0] Dato_out;
  logic         dato_valido;
  logic         bloqueado;
  logic         error_sinc;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit solo_err;
    int valor;
    bit err;
    int gap;
  } esp_t;

  esp_t q[$];

  pwm_demodulador #(
    .PERIODO_BITS (N),
    .SYNC_STAGES  (2)
  ) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .PWM_in      (PWM_in),
    .Dato_out    (Dato_out),
    .dato_valido (dato_valido),
    .bloqueado   (bloqueado),
    .error_sinc  (error_sinc)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic esperar(input bit solo_err, input int valor, input bit err, input int gap);
    esp_t e;
    e.solo_err = solo_err;
    e.valor    = valor;
    e.err      = err;
    e.gap      = gap;
    q.push_back(e);
  endtask

  task automatic chk(input string nombre, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nombre, act, req);
    end
  endtask

  task automatic ciclo(input logic v);
    @(posedge clk_in);
    #1 PWM_in = v;
  endtask

  // Generator: phase g of a 2**N period, line high while g < duty.
  task automatic linea(input int d, input int desde, input int hasta);
    for (int g = desde; g < hasta; g++) ciclo(g < d);
  endtask

  task automatic periodo(input int d, input int gap);
    esperar(1'b0, d, 1'b0, gap);
    linea(d, 0, PER);
  endtask

  task automatic reiniciar();
    @(posedge clk_in);
    #3 rst_n = 1'b0;
    PWM_in = 1'b0;
    #1 chk("reset_salidas", int'({Dato_out, dato_valido, bloqueado, error_sinc}), 0);
    q.delete();
    repeat (3) ciclo(1'b0);
    @(posedge clk_in);
    #1 rst_n = 1'b1;
    repeat (8) ciclo(1'b0);
  endtask

  initial begin : monitor
    int   ultimo;
    esp_t e;
    bit   ok;
    ultimo = 0;
    forever begin
      @(negedge clk_in);
      if (rst_n && (dato_valido || error_sinc)) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL evento_inesperado: valido=%0b dato=%0d err=%0b at cycle %0d, expected no event",
                   dato_valido, Dato_out, error_sinc, cyc);
        end else begin
          e  = q.pop_front();
          ok = (dato_valido == !e.solo_err) && (error_sinc == e.err) &&
               (e.solo_err || (int'(Dato_out) == e.valor)) &&
               (e.gap == 0 || (cyc - ultimo) == e.gap);
          if (!ok) begin
            n_fail++;
            $display("FAIL evento: valido=%0b dato=%0d err=%0b gap=%0d, expected valido=%0b dato=%0d err=%0b gap=%0d",
                     dato_valido, Dato_out, error_sinc, cyc - ultimo,
                     !e.solo_err, e.valor, e.err, e.gap);
          end
        end
        ultimo = cyc;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : estimulo
    repeat (3) @(posedge clk_in);

    // Line never rises: unlocked zero strobes every period, no error.
    reiniciar();
    esperar(1'b0, 0, 1'b0, 0);
    esperar(1'b0, 0, 1'b0, PER);
    esperar(1'b0, 0, 1'b0, PER);
    repeat (780) ciclo(1'b0);
    chk("buscar_pendientes", q.size(), 0);
    chk("buscar_bloqueado", int'(bloqueado), 0);

    // Locked run: fixed corner duties then random ones.
    reiniciar();
    periodo(128, 0);
    periodo(128, PER);
    periodo(1, PER);
    periodo(255, PER);
    periodo(0, PER);
    for (int i = 0; i < 12; i++) begin
      int r, d;
      r = $urandom_range(0, 9);
      if (r == 0)      d = 0;
      else if (r == 1) d = PER - 1;
      else             d = $urandom_range(0, PER - 1);
      periodo(d, PER);
    end
    repeat (20) ciclo(1'b0);
    chk("aleatorio_pendientes", q.size(), 0);
    chk("aleatorio_bloqueado", int'(bloqueado), 1);

    // Stuck high: saturated value with error on each strobe.
    reiniciar();
    esperar(1'b0, PER - 1, 1'b1, 0);
    esperar(1'b0, PER - 1, 1'b1, PER);
    repeat (600) ciclo(1'b1);
    repeat (20) ciclo(1'b0);
    chk("alto_pendientes", q.size(), 0);

    // Extra edge at phase 100: error only, period restarts from that edge.
    reiniciar();
    periodo(50, 0);
    linea(50, 0, 100);
    esperar(1'b1, 0, 1'b1, 101);
    periodo(50, PER - 1);
    periodo(50, PER);
    repeat (20) ciclo(1'b0);
    chk("flanco_pendientes", q.size(), 0);
    chk("flanco_bloqueado", int'(bloqueado), 1);

    // Reset mid-period, relock on the next true period boundary.
    reiniciar();
    periodo(200, 0);
    periodo(200, PER);
    linea(200, 0, 50);
    chk("prereset_pendientes", q.size(), 0);
    #2 rst_n = 1'b0;
    #1 chk("reset_asincrono", int'({Dato_out, dato_valido, bloqueado, error_sinc}), 0);
    linea(200, 50, 220);
    @(posedge clk_in);
    #1 rst_n = 1'b1;
    PWM_in = 1'b0;
    linea(200, 221, PER);
    periodo(200, 0);
    periodo(200, PER);
    repeat (20) ciclo(1'b0);
    chk("relock_pendientes", q.size(), 0);
    chk("relock_dato", int'(Dato_out), 200);
    chk("relock_bloqueado", int'(bloqueado), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
